sccb_responder: RTL

SCCB_RESPONDER -- requirements
Module: sccb_responder

---
 rtl/sccb_pkg.sv | 32 +++
 rtl/sccb_line_sync.sv | 37 +++
 rtl/sccb_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Constants shared by the SCCB responder and the SCCB transmitter:
// FSM state encodings, ID-byte layout and the default device ID.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ID_BYTE    = 4'd1,
    ST_ID_ACK     = 4'd2,
    ST_SUB_BYTE   = 4'd3,
    ST_SUB_ACK    = 4'd4,
    ST_WDATA_BYTE = 4'd5,
    ST_WDATA_ACK  = 4'd6,
    ST_RDATA_BYTE = 4'd7,
    ST_RDATA_NA   = 4'd8,
    ST_IGNORE     = 4'd9
  } sccb_state_e;

  localparam logic [6:0]  SCCB_DEFAULT_ID = 7'h21;
  localparam int unsigned SCCB_RW_BIT     = 0;
  localparam logic        SCCB_RW_WRITE   = 1'b0;
  localparam logic        SCCB_RW_READ    = 1'b1;

  function automatic logic [7:0] sccb_id_byte(input logic [6:0] id, input logic rw);
    return {id, rw};
  endfunction

  // Compares the 7 ID bits, ignoring the R/W bit in the LSB.
  function automatic logic sccb_id_match(input logic [7:0] id_byte, input logic [6:0] id);
    return id_byte[7:1] == id;
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Multi-flop synchronizer for one asynchronous SCCB line, plus edge
// detection between the last synchronizer stage and one extra delay flop.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = (sync_q << 1) | SYNC_STAGES'(d_async);
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

  // Reset to the idle bus level so a reset never manufactures an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      dly_q  <= 1'b1;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

endmodule

// File: rtl/sccb_responder.sv
// SCCB (3-wire) slave: receives ID / sub-address / data bytes, drives
// ACK and read data open-drain, and strobes a simple register port.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEVICE_ID   = SCCB_DEFAULT_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_p,
  input  logic       i_sio_c,
  input  logic       i_sio_d,
  output logic       o_sio_d_oe,
  input  logic       i_sccb_e,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_we,
  input  logic [7:0] i_reg_rdata,
  output logic       o_reg_re,
  output logic       o_busy,
  output logic       o_id_mismatch
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic e_lvl, e_rise, e_fall;
  logic unused_e_edges;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scl (
    .clk(i_clk), .rst(i_reset_p), .d_async(i_sio_c),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sda (
    .clk(i_clk), .rst(i_reset_p), .d_async(i_sio_d),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_e (
    .clk(i_clk), .rst(i_reset_p), .d_async(i_sccb_e),
    .level(e_lvl), .rise(e_rise), .fall(e_fall)
  );

  assign unused_e_edges = e_rise ^ e_fall;

  logic start_cond, stop_cond;
  assign start_cond = sda_fall & scl_lvl & ~e_lvl;
  assign stop_cond  = sda_rise & scl_lvl;

  sccb_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ack_phase_q, ack_phase_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        re_q, re_d;
  logic        mm_q, mm_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_byte;

  assign rx_byte = {shift_q[6:0], sda_lvl};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ack_phase_d = ack_phase_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    mm_d        = 1'b0;
    shift_d     = shift_q;
    tx_d        = tx_q;

    // Bus-level events outrank bit sampling in the same cycle.
    if (e_lvl) begin
      state_d     = ST_IDLE;
      cnt_d       = 3'd0;
      ack_phase_d = 1'b0;
      oe_d        = 1'b0;
      busy_d      = 1'b0;
    end else if (start_cond) begin
      state_d     = ST_ID_BYTE;
      cnt_d       = 3'd0;
      ack_phase_d = 1'b0;
      oe_d        = 1'b0;
      busy_d      = 1'b1;
    end else if (stop_cond) begin
      state_d     = ST_IDLE;
      cnt_d       = 3'd0;
      ack_phase_d = 1'b0;
      oe_d        = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        ST_ID_BYTE, ST_SUB_BYTE, ST_WDATA_BYTE: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ack_phase_d = 1'b0;
              if (state_q == ST_ID_BYTE) begin
                state_d = ST_ID_ACK;
              end else if (state_q == ST_SUB_BYTE) begin
                state_d = ST_SUB_ACK;
                addr_d  = rx_byte;
              end else begin
                state_d = ST_WDATA_ACK;
                wdata_d = rx_byte;
                we_d    = 1'b1;
              end
            end
          end
        end

        // First falling edge opens the ACK slot, the second closes it.
        ST_ID_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              if (sccb_id_match(shift_q, DEVICE_ID)) begin
                oe_d        = 1'b1;
                ack_phase_d = 1'b1;
              end else begin
                mm_d    = 1'b1;
                state_d = ST_IGNORE;
              end
            end else begin
              ack_phase_d = 1'b0;
              cnt_d       = 3'd0;
              if (shift_q[SCCB_RW_BIT] == SCCB_RW_READ) begin
                state_d = ST_RDATA_BYTE;
                re_d    = 1'b1;
                oe_d    = ~i_reg_rdata[7];
                tx_d    = {i_reg_rdata[6:0], 1'b0};
              end else begin
                state_d = ST_SUB_BYTE;
                oe_d    = 1'b0;
              end
            end
          end
        end

        ST_SUB_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              oe_d        = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              oe_d        = 1'b0;
              ack_phase_d = 1'b0;
              cnt_d       = 3'd0;
              state_d     = (state_q == ST_SUB_ACK) ? ST_WDATA_BYTE : ST_IGNORE;
            end
          end
        end

        // MSB was already placed on the bus when ID_ACK ended.
        ST_RDATA_BYTE: begin
          if (scl_fall) begin
            if (cnt_q == 3'd7) begin
              oe_d    = 1'b0;
              cnt_d   = 3'd0;
              state_d = ST_RDATA_NA;
            end else begin
              oe_d  = ~tx_q[7];
              tx_d  = {tx_q[6:0], 1'b0};
              cnt_d = cnt_q + 3'd1;
            end
          end
        end

        ST_RDATA_NA: begin
          if (scl_fall) begin
            state_d = ST_IGNORE;
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_p) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      ack_phase_q <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      mm_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_phase_q <= ack_phase_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      re_q        <= re_d;
      mm_q        <= mm_d;
    end
  end

  always_ff @(posedge i_clk) begin
    shift_q <= shift_d;
    tx_q    <= tx_d;
  end

  assign o_sio_d_oe    = oe_q;
  assign o_busy        = busy_q;
  assign o_reg_addr    = addr_q;
  assign o_reg_wdata   = wdata_q;
  assign o_reg_we      = we_q;
  assign o_reg_re      = re_q;
  assign o_id_mismatch = mm_q;

endmodule
